pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100, redirect target on misaligned-target trap.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-004 imem_req_valid  out  1  fetch request valid.
REQ-005 imem_req_ready  in  1  imem accepts request.
REQ-006 imem_addr  out  32  fetch address.
REQ-007 imem_rsp_valid  in  1  instruction data returned (data path bypasses this block).
REQ-008 if_valid  out  1  fetched instruction valid to decode.
REQ-009 if_pc  out  32  PC of instruction presented with if_valid.
REQ-010 id_ready  in  1  decode accepts instruction.
REQ-011 br_en  in  1  EX holds a conditional branch; br_taken  in  1  branch comparator result.
REQ-012 jmp_en  in  1  EX holds JAL/JALR; br_target  in  32  computed branch/jump target.
REQ-013 flush  out  1  kill IF/ID contents.
REQ-014 trap  out  1  misaligned-target trap pulse (driven 0 when feature compiled out).

Function
REQ-015 SHALL implement FSM states RST, REQ, WAIT, HOLD.
REQ-016 RST: entered on reset; next cycle unconditionally -> REQ with pc = RESET_PC.
REQ-017 REQ: imem_req_valid=1, imem_addr=pc; on imem_req_ready -> WAIT, else stay.
REQ-018 WAIT: on imem_rsp_valid assert if_valid, if_pc=pc; if id_ready in same cycle, pc<=pc+4 and -> REQ, else -> HOLD.
REQ-019 HOLD: if_valid=1, if_pc=pc held stable; on id_ready, pc<=pc+4 -> REQ.
REQ-020 At most one request outstanding; imem_req_valid SHALL be 0 outside REQ.
REQ-021 Redirect = jmp_en | (br_en & br_taken); flush=1 combinationally in the redirect cycle.
REQ-022 On redirect in any state except RST: pc<=br_target, if_valid forced 0 that cycle, next state REQ.
REQ-023 Redirect while in WAIT with response not yet returned: set drop flag; next imem_rsp_valid SHALL be discarded (no if_valid), and FSM stays in REQ/WAIT for the new target as normal.
REQ-024 Redirect in REQ with imem_req_ready=1 same cycle: accepted request becomes drop-flagged, as REQ-023.
REQ-025 Redirect takes priority over id_ready and imem_rsp_valid in the same cycle.
REQ-026 Redirect-to-new-request latency: exactly one cycle (imem_req_valid with new target in the cycle after flush, unless drop pending, then after the dropped response).
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-028 br_en with br_taken=0 and jmp_en=0: no flush, no pc change.

Reset
REQ-029 During rst_n=0: state=RST, pc=RESET_PC, drop flag=0, imem_req_valid=0, if_valid=0, flush=0, trap=0, if_pc=RESET_PC, imem_addr=RESET_PC.
REQ-030 Reset mid-request SHALL abandon the outstanding request; a stale response after reset release before first REQ SHALL be ignored.

Configuration
REQ-031 Macro PC_CTRL_MISALIGN_TRAP_EN: when defined, a redirect with br_target[1:0]!=0 SHALL pulse trap=1 for one cycle with flush=1 and load pc<=TRAP_VEC instead of br_target.
REQ-032 Without PC_CTRL_MISALIGN_TRAP_EN: trap tied 0; br_target[1:0] forced to 0 when loaded into pc.

Structure
REQ-033 Shared package SHALL hold the FSM state enum (RST, REQ, WAIT, HOLD), XLEN=32 and instruction step constant 4.
REQ-034 Single flat module; no sub-module required; pc register, drop flag and FSM in one sequential process, outputs combinational from state.

Verification
REQ-035 Reset release, imem_req_ready=1, 1-cycle rsp, id_ready=1 -> imem_addr 0x0,0x4,0x8 on successive requests, if_pc matches.
REQ-036 id_ready=0 for 3 cycles after rsp -> if_valid held, if_pc=0x4 stable, no new request until id_ready=1.
REQ-037 br_en=1, br_taken=1, br_target=0x40 while in WAIT -> flush=1 that cycle, pending rsp dropped, next request addr 0x40.
REQ-038 br_en=1, br_taken=0 -> flush=0, sequential fetch continues unchanged.
REQ-039 pc=0xFFFF_FFFC accepted by decode -> next imem_addr=0x0.
REQ-040 With PC_CTRL_MISALIGN_TRAP_EN, jmp_en=1, br_target=0x42 -> trap=1, flush=1 one cycle, next imem_addr=0x100; without macro -> next imem_addr=0x40, trap=0.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg -- shared definitions for the program-counter / fetch controller.
// Holds the fetch FSM state encoding, the architectural word width and the
// sequential instruction step, plus a helper for the wrapping PC increment.
package pc_ctrl_pkg;

  localparam int XLEN = 32;

  // Byte distance between consecutive sequential instructions.
  localparam logic [XLEN-1:0] INSN_STEP = 32'd4;

  // Fetch FSM states.
  //   RST  : first cycle after reset, loads the reset PC
  //   REQ  : presenting a fetch request to imem
  //   WAIT : request accepted, waiting for the instruction to return
  //   HOLD : instruction returned but decode has not taken it yet
  typedef enum logic [1:0] {
    RST  = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Sequential successor of a PC; the add naturally wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + INSN_STEP;
  endfunction

endpackage

// File: rtl/pc_ctrl.sv
// pc_ctrl -- program counter and instruction-fetch request controller.
//
// Issues one fetch request at a time to imem, tracks the returned
// instruction (data itself bypasses this block), hands the PC to decode
// with if_valid, and redirects on taken branches / jumps from EX.
//
// A redirect that arrives while a request is in flight cannot cancel it at
// imem, so the in-flight response is marked with drop_reg and swallowed
// when it returns; the new request is only issued after that, keeping a
// single outstanding request at all times.
//
// Build option: define PC_CTRL_MISALIGN_TRAP_EN to trap redirects whose
// target is not word aligned (pc goes to TRAP_VEC and trap pulses).
// Without it, trap is tied low and target bits [1:0] are cleared.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction memory request side
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  // decode side
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  // execute-stage redirect inputs
  input  logic            br_en,
  input  logic            br_taken,
  input  logic            jmp_en,
  input  logic [XLEN-1:0] br_target,
  // control outputs
  output logic            flush,
  output logic            trap
);

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic            drop_reg;

  logic            redirect;
  logic            req_accept;
  logic [XLEN-1:0] redirect_pc;

  // A redirect only counts once the FSM has left its reset state.
  assign redirect = (jmp_en | (br_en & br_taken)) & (state_reg != RST);

  // A request is handed over when we present it and imem takes it.
  assign req_accept = imem_req_valid & imem_req_ready;

`ifdef PC_CTRL_MISALIGN_TRAP_EN
  logic target_misaligned;

  assign target_misaligned = |br_target[1:0];

  // Misaligned targets are diverted to the trap vector with a one-cycle pulse.
  always_comb begin
    trap        = redirect & target_misaligned;
    redirect_pc = target_misaligned ? TRAP_VEC : br_target;
  end
`else
  // No trap support: silently word-align the target.
  always_comb begin
    trap        = 1'b0;
    redirect_pc = br_target & ~32'h0000_0003;
  end
`endif

  // Outputs decoded from the current state; a redirect suppresses delivery.
  always_comb begin
    flush          = redirect;
    imem_req_valid = (state_reg == REQ) & ~drop_reg;
    imem_addr      = pc_reg;
    if_pc          = pc_reg;
    if_valid       = 1'b0;
    if (!redirect) begin
      if (state_reg == WAIT) begin
        if_valid = imem_rsp_valid;
      end else if (state_reg == HOLD) begin
        if_valid = 1'b1;
      end
    end
  end

  // Fetch FSM with the PC register and the stale-response drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RST;
      pc_reg    <= RESET_PC;
      drop_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RST: begin
          // Any response seen here belongs to a request abandoned by reset.
          state_reg <= REQ;
          pc_reg    <= RESET_PC;
          drop_reg  <= 1'b0;
        end

        REQ: begin
          if (redirect) begin
            // A request accepted in the redirect cycle is now stale; an
            // already-pending drop clears if its response shows up now.
            pc_reg    <= redirect_pc;
            state_reg <= REQ;
            drop_reg  <= req_accept | (drop_reg & ~imem_rsp_valid);
          end else if (drop_reg) begin
            // Hold off the new request until the stale response is gone.
            if (imem_rsp_valid) begin
              drop_reg <= 1'b0;
            end
          end else if (imem_req_ready) begin
            state_reg <= WAIT;
          end
        end

        WAIT: begin
          if (redirect) begin
            // If the response arrives in this very cycle it is discarded
            // here; otherwise it is still in flight and must be dropped.
            pc_reg    <= redirect_pc;
            state_reg <= REQ;
            drop_reg  <= ~imem_rsp_valid;
          end else if (imem_rsp_valid) begin
            if (id_ready) begin
              pc_reg    <= next_seq_pc(pc_reg);
              state_reg <= REQ;
            end else begin
              state_reg <= HOLD;
            end
          end
        end

        HOLD: begin
          if (redirect) begin
            pc_reg    <= redirect_pc;
            state_reg <= REQ;
          end else if (id_ready) begin
            pc_reg    <= next_seq_pc(pc_reg);
            state_reg <= REQ;
          end
        end

        default: begin
          state_reg <= RST;
          drop_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl -- directed bench for pc_ctrl.
// Expected fetch addresses and expected decode PCs are queued as stimulus is
// driven and popped when the DUT hands over a request or an instruction.
// Honours PC_CTRL_MISALIGN_TRAP_EN for the misaligned-jump expectations.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        br_en;
  logic        br_taken;
  logic        jmp_en;
  logic [31:0] br_target;
  logic        flush;
  logic        trap;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];

`ifdef PC_CTRL_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_PC   = 32'h0000_0100;
  localparam logic        TRAP_EXP = 1'b1;
`else
  localparam logic [31:0] MIS_PC   = 32'h0000_0040;
  localparam logic        TRAP_EXP = 1'b0;
`endif

  pc_ctrl #(
    .RESET_PC(32'h0000_0000),
    .TRAP_VEC(32'h0000_0100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .id_ready      (id_ready),
    .br_en         (br_en),
    .br_taken      (br_taken),
    .jmp_en        (jmp_en),
    .br_target     (br_target),
    .flush         (flush),
    .trap          (trap)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every handed-over request and instruction.
  task automatic mon();
    logic [31:0] e;
    if (imem_req_valid && imem_req_ready) begin
      $display("req  addr=%h", imem_addr);
      if (exp_addr_q.size() == 0) begin
        chk1("req_unexpected", imem_req_valid, 1'b0);
      end else begin
        e = exp_addr_q.pop_front();
        chk32("req_addr", imem_addr, e);
      end
    end
    if (if_valid && id_ready) begin
      $display("dec  pc=%h", if_pc);
      if (exp_pc_q.size() == 0) begin
        chk1("dec_unexpected", if_valid, 1'b0);
      end else begin
        e = exp_pc_q.pop_front();
        chk32("dec_pc", if_pc, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
    mon();
  endtask

  task automatic idle();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    id_ready       = 1'b0;
    br_en          = 1'b0;
    br_taken       = 1'b0;
    jmp_en         = 1'b0;
    br_target      = 32'h0;
  endtask

  initial begin
    // Reset held with every input active: nothing may leak out.
    idle();
    rst_n = 1'b0;
    imem_rsp_valid = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
    br_en = 1'b1; br_taken = 1'b1; jmp_en = 1'b1; br_target = 32'h42;
    tick(); half();
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_flush", flush, 1'b0);
    chk1("rst_trap", trap, 1'b0);
    chk32("rst_if_pc", if_pc, 32'h0);
    chk32("rst_imem_addr", imem_addr, 32'h0);
    tick();

    // Release; RST cycle with a stale response must be ignored.
    idle(); rst_n = 1'b1;
    imem_rsp_valid = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
    half();
    chk1("rstcyc_req_valid", imem_req_valid, 1'b0);
    chk1("rstcyc_if_valid", if_valid, 1'b0);
    tick();

    // Sequential fetch 0x0, 0x4.
    idle(); imem_req_ready = 1'b1; exp_addr_q.push_back(32'h0); half(); tick();
    idle(); imem_rsp_valid = 1'b1; id_ready = 1'b1; exp_pc_q.push_back(32'h0); half(); tick();
    idle(); imem_req_ready = 1'b1; exp_addr_q.push_back(32'h4); half(); tick();

    // Response with decode stalled: instruction held for three cycles.
    idle(); imem_rsp_valid = 1'b1; half();
    chk1("stall_if_valid", if_valid, 1'b1);
    chk32("stall_if_pc", if_pc, 32'h4);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle(); imem_req_ready = 1'b1; half();
      chk1("hold_if_valid", if_valid, 1'b1);
      chk32("hold_if_pc", if_pc, 32'h4);
      chk1("hold_req_valid", imem_req_valid, 1'b0);
      tick();
    end
    idle(); id_ready = 1'b1; exp_pc_q.push_back(32'h4); half(); tick();
    idle(); imem_req_ready = 1'b1; exp_addr_q.push_back(32'h8); half(); tick();

    // Taken branch while waiting: flush, in-flight response dropped.
    idle(); br_en = 1'b1; br_taken = 1'b1; br_target = 32'h40; id_ready = 1'b1; half();
    chk1("br_flush", flush, 1'b1);
    chk1("br_if_valid", if_valid, 1'b0);
    chk1("br_trap", trap, 1'b0);
    tick();
    idle(); imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; id_ready = 1'b1; half();
    chk1("drop_req_valid", imem_req_valid, 1'b0);
    chk1("drop_if_valid", if_valid, 1'b0);
    tick();
    idle(); imem_req_ready = 1'b1; exp_addr_q.push_back(32'h40); half();
    chk1("br_new_req_valid", imem_req_valid, 1'b1);
    tick();

    // Not-taken branch: no flush, sequential flow continues.
    idle(); imem_rsp_valid = 1'b1; id_ready = 1'b1;
    br_en = 1'b1; br_taken = 1'b0; br_target = 32'h200;
    exp_pc_q.push_back(32'h40); half();
    chk1("nt_flush", flush, 1'b0);
    tick();
    idle(); half();
    chk1("nt_req_valid", imem_req_valid, 1'b1);
    chk32("nt_imem_addr", imem_addr, 32'h44);
    tick();
    idle(); imem_req_ready = 1'b1; exp_addr_q.push_back(32'h44); half(); tick();
    idle(); imem_rsp_valid = 1'b1; half();
    chk1("nt_if_valid", if_valid, 1'b1);
    tick();

    // Jump from HOLD beats id_ready; target is the top word of memory.
    idle(); jmp_en = 1'b1; br_target = 32'hFFFF_FFFC; id_ready = 1'b1; half();
    chk1("jhold_flush", flush, 1'b1);
    chk1("jhold_if_valid", if_valid, 1'b0);
    tick();
    idle(); imem_req_ready = 1'b1; exp_addr_q.push_back(32'hFFFF_FFFC); half(); tick();
    idle(); imem_rsp_valid = 1'b1; id_ready = 1'b1; exp_pc_q.push_back(32'hFFFF_FFFC); half(); tick();
    // PC wraps to zero.
    idle(); imem_req_ready = 1'b1; exp_addr_q.push_back(32'h0); half(); tick();

    // Misaligned jump with the response arriving in the same cycle.
    idle(); imem_rsp_valid = 1'b1; id_ready = 1'b1; jmp_en = 1'b1; br_target = 32'h42; half();
    chk1("mis_flush", flush, 1'b1);
    chk1("mis_trap", trap, TRAP_EXP);
    chk1("mis_if_valid", if_valid, 1'b0);
    tick();
    // Next cycle issues the new target; redirect again as it is accepted.
    idle(); imem_req_ready = 1'b1; exp_addr_q.push_back(MIS_PC);
    jmp_en = 1'b1; br_target = 32'h80; half();
    chk1("mis_next_req_valid", imem_req_valid, 1'b1);
    chk1("reqacc_flush", flush, 1'b1);
    chk1("reqacc_trap", trap, 1'b0);
    tick();
    idle(); imem_req_ready = 1'b1; half();
    chk1("reqacc_wait_req_valid", imem_req_valid, 1'b0);
    tick();
    idle(); imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; id_ready = 1'b1; half();
    chk1("reqacc_drop_req_valid", imem_req_valid, 1'b0);
    chk1("reqacc_drop_if_valid", if_valid, 1'b0);
    tick();
    idle(); imem_req_ready = 1'b1; exp_addr_q.push_back(32'h80); half(); tick();
    idle(); imem_rsp_valid = 1'b1; id_ready = 1'b1; exp_pc_q.push_back(32'h80); half(); tick();
    idle(); imem_req_ready = 1'b1; exp_addr_q.push_back(32'h84); half(); tick();

    // Reset while a request is outstanding.
    idle(); rst_n = 1'b0; half();
    chk1("midrst_req_valid", imem_req_valid, 1'b0);
    chk1("midrst_if_valid", if_valid, 1'b0);
    chk32("midrst_imem_addr", imem_addr, 32'h0);
    chk32("midrst_if_pc", if_pc, 32'h0);
    tick();
    idle(); rst_n = 1'b1; imem_rsp_valid = 1'b1; id_ready = 1'b1; imem_req_ready = 1'b1; half();
    chk1("stale_req_valid", imem_req_valid, 1'b0);
    chk1("stale_if_valid", if_valid, 1'b0);
    tick();
    idle(); imem_req_ready = 1'b1; exp_addr_q.push_back(32'h0); half(); tick();
    idle(); imem_rsp_valid = 1'b1; id_ready = 1'b1; exp_pc_q.push_back(32'h0); half(); tick();

    idle(); half();
    chk32("addr_q_left", 32'(exp_addr_q.size()), 32'd0);
    chk32("pc_q_left", 32'(exp_pc_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
